// File: rtl/mem_stage_ext.sv
// Pipeline memory stage between EXE and WB: owns the data memory, performs
// byte/half/word loads and stores with extension and stalls upstream for MEM_LATENCY cycles.
module mem_stage_ext #(
  parameter int WORD_LEN    = 32,
  parameter int ADDRESS_LEN = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] pc_in,
  output logic [ADDRESS_LEN-1:0] pc,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [1:0]             MEM_SIZE,
  input  logic                   MEM_SIGNED,
  input  logic [ADDRESS_LEN-1:0] ALU_Res,
  input  logic [WORD_LEN-1:0]    Val_RM,
  output logic [WORD_LEN-1:0]    memory_out,
  output logic                   ready,
  output logic                   freeze,
  output logic                   fault
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned DEPTH_U = DEPTH_WORDS;
  localparam logic [3:0]  LAT     = 4'(MEM_LATENCY);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0]  mem_out_q, mem_out_d;
  logic [WORD_LEN-1:0]  mem_q [DEPTH_WORDS];

  logic                   req, bad, misalign, below, beyond, done, mem_we;
  logic [ADDRESS_LEN-1:0] offset;
  logic [IDX_W-1:0]       idx;
  logic [WORD_LEN-1:0]    rd_word, wr_word, load_val;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;

  // Request validation
  always_comb begin
    req      = MEM_R_EN | MEM_W_EN;
    offset   = ALU_Res - ADDRESS_LEN'(BASE_ADDR);
    below    = ALU_Res < ADDRESS_LEN'(BASE_ADDR);
    beyond   = (offset >> 2) >= ADDRESS_LEN'(DEPTH_WORDS);
    misalign = ((MEM_SIZE == 2'b01) && ALU_Res[0]) ||
               ((MEM_SIZE == 2'b10) && (ALU_Res[1:0] != 2'b00));
    bad      = (MEM_R_EN & MEM_W_EN) | (MEM_SIZE == 2'b11) | misalign | below | beyond;
    idx      = offset[IDX_W+1:2];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req && !bad && (LAT != 4'd0)) begin
          state_d = S_WAIT;
          cnt_d   = 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs; held low while reset is asserted so a reset abandons any pending write
  always_comb begin
    ready  = 1'b0;
    freeze = 1'b0;
    fault  = 1'b0;
    done   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (bad) begin
              fault = 1'b1;
              ready = 1'b1;
            end else if (LAT == 4'd0) begin
              ready = 1'b1;
              done  = 1'b1;
            end else begin
              freeze = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == LAT) begin
            ready = 1'b1;
            done  = 1'b1;
          end else begin
            freeze = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Lane extraction and merge, little-endian
  always_comb begin
    rd_word = mem_q[idx];
    byte_v  = rd_word[{ALU_Res[1:0], 3'b000} +: 8];
    half_v  = rd_word[{ALU_Res[1], 4'b0000} +: 16];
    case (MEM_SIZE)
      2'b00:   load_val = {{(WORD_LEN-8){MEM_SIGNED & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{(WORD_LEN-16){MEM_SIGNED & half_v[15]}}, half_v};
      default: load_val = rd_word;
    endcase
    wr_word = rd_word;
    case (MEM_SIZE)
      2'b00:   wr_word[{ALU_Res[1:0], 3'b000} +: 8] = Val_RM[7:0];
      2'b01:   wr_word[{ALU_Res[1], 4'b0000} +: 16] = Val_RM[15:0];
      default: wr_word = Val_RM;
    endcase
    mem_we     = done & MEM_W_EN;
    mem_out_d  = (done & MEM_R_EN) ? load_val : mem_out_q;
    memory_out = mem_out_d;
    pc_d       = freeze ? pc_q : pc_in;
    pc         = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      mem_out_q <= '0;
      for (int unsigned i = 0; i < DEPTH_U; i++) mem_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      mem_out_q <= mem_out_d;
      if (mem_we) mem_q[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Bench for mem_stage_ext: four instances with MEM_LATENCY 0..3 checked against
// a byte-array memory model, a vector table and hand-written timing sequences.
module tb_mem_stage_ext;

  localparam int N = 4;

  logic        clk;
  logic        rst_s    [N];
  logic [31:0] pc_in_s  [N];
  logic [31:0] pc_s     [N];
  logic        re_s     [N];
  logic        we_s     [N];
  logic [1:0]  sz_s     [N];
  logic        sg_s     [N];
  logic [31:0] addr_s   [N];
  logic [31:0] wd_s     [N];
  logic [31:0] mo_s     [N];
  logic        ready_s  [N];
  logic        freeze_s [N];
  logic        fault_s  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_stage_ext #(
      .WORD_LEN(32), .ADDRESS_LEN(32), .DEPTH_WORDS(64), .BASE_ADDR(1024), .MEM_LATENCY(g)
    ) u_dut (
      .clk(clk), .rst(rst_s[g]), .pc_in(pc_in_s[g]), .pc(pc_s[g]),
      .MEM_R_EN(re_s[g]), .MEM_W_EN(we_s[g]), .MEM_SIZE(sz_s[g]), .MEM_SIGNED(sg_s[g]),
      .ALU_Res(addr_s[g]), .Val_RM(wd_s[g]), .memory_out(mo_s[g]),
      .ready(ready_s[g]), .freeze(freeze_s[g]), .fault(fault_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mb       [N][256];
  logic [31:0] last_out [N];
  logic [31:0] pc_exp   [N];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat %0d) @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic mdl_fault(logic re, logic we, logic [1:0] sz, logic [31:0] addr);
    if (re && we) return 1'b1;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && addr[0]) return 1'b1;
    if (sz == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
    if (addr < 32'd1024) return 1'b1;
    if (((addr - 32'd1024) >> 2) >= 32'd64) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(int k, logic [1:0] sz, logic sg, logic [31:0] addr);
    int n = 1 << sz;
    int off = int'(addr - 32'd1024);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[k][off+i];
    if (sg && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic mdl_reset(input int k);
    for (int i = 0; i < 256; i++) mb[k][i] = 8'h00;
    last_out[k] = '0;
    pc_exp[k]   = '0;
  endtask

  task automatic set_idle(input int k);
    re_s[k] = 1'b0; we_s[k] = 1'b0; sz_s[k] = 2'b00; sg_s[k] = 1'b0;
  endtask

  // Performs one access starting at posedge+1; returns at posedge+1 after completion.
  task automatic access(input int k, input logic re, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] pcv, output logic got_fault, output logic [31:0] got_data);
    logic        ef;
    logic [31:0] ed, pc_old;
    int          fr;
    bit          done;
    ef = mdl_fault(re, we, sz, addr);
    ed = (re && !ef) ? mdl_load(k, sz, sg, addr) : last_out[k];
    pc_old = pc_exp[k];
    re_s[k] = re; we_s[k] = we; sz_s[k] = sz; sg_s[k] = sg;
    addr_s[k] = addr; wd_s[k] = wd; pc_in_s[k] = pcv;
    fr = 0; done = 0; got_fault = 1'b0; got_data = '0;
    for (int c = 0; c < 24 && !done; c++) begin
      @(negedge clk);
      if (ready_s[k]) begin
        done = 1;
        got_fault = fault_s[k];
        got_data  = mo_s[k];
        chk("freeze_at_ready", k, 32'(freeze_s[k]), 32'd0);
        chk("memory_out_at_ready", k, mo_s[k], ed);
      end else begin
        if (freeze_s[k]) fr++;
        chk("pc_hold_while_frozen", k, pc_s[k], pc_old);
        chk("fault_while_waiting", k, 32'(fault_s[k]), 32'd0);
        chk("memory_out_while_waiting", k, mo_s[k], last_out[k]);
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout (lat %0d): no ready within 24 cycles", k);
    end
    chk("fault_flag", k, 32'(got_fault), 32'(ef));
    chk("freeze_cycles", k, fr, ef ? 0 : k);
    @(posedge clk); #1;
    set_idle(k);
    if (!ef) begin
      if (we) for (int i = 0; i < (1 << sz); i++) mb[k][int'(addr - 32'd1024) + i] = wd[8*i +: 8];
      if (re) last_out[k] = ed;
    end
    pc_exp[k] = pcv;
    chk("pc_after_access", k, pc_s[k], pcv);
    chk("memory_out_held", k, mo_s[k], last_out[k]);
  endtask

  typedef struct {
    logic        re, we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr, wd;
    logic        ef;
    logic [31:0] ed;
  } vec_t;

  vec_t        tbl [15];
  logic        gf;
  logic [31:0] gd;
  int          c0;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1032, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'd1033, 32'h000000AA, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1032, 32'h0,        1'b0, 32'h1122AA44};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'd1033, 32'h0,        1'b0, 32'hFFFFFFAA};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd1034, 32'h0,        1'b0, 32'h00001122};
    tbl[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd1025, 32'h0,        1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1020, 32'h55555555, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1280, 32'h66666666, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h77777777, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'd1024, 32'h0,        1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'd1032, 32'h0,        1'b0, 32'hFFFFAA44};
    tbl[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1276, 32'h0,        1'b0, 32'h00000000};

    for (int k = 0; k < N; k++) begin
      rst_s[k] = 1'b1; pc_in_s[k] = 32'h100 + 32'(k); addr_s[k] = '0; wd_s[k] = '0;
      set_idle(k);
      mdl_reset(k);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("reset_pc", k, pc_s[k], 32'h0);
      chk("reset_ready", k, 32'(ready_s[k]), 32'd0);
      chk("reset_freeze", k, 32'(freeze_s[k]), 32'd0);
      chk("reset_fault", k, 32'(fault_s[k]), 32'd0);
      chk("reset_memory_out", k, mo_s[k], 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) pc_exp[k] = 32'h100 + 32'(k);

    // Directed vectors on the zero-latency instance
    for (int i = 0; i < 15; i++) begin
      access(0, tbl[i].re, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd,
             32'h2000 + 32'(i), gf, gd);
      chk("tbl_fault", 0, 32'(gf), 32'(tbl[i].ef));
      if (tbl[i].re && !tbl[i].ef) chk("tbl_data", 0, gd, tbl[i].ed);
    end

    // Latency 2: two frozen cycles, pc held, then ready
    access(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1028, 32'hCAFEF00D, 32'h3000, gf, gd);
    c0 = cyc;
    access(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0, 32'h3004, gf, gd);
    chk("lat2_read_data", 2, gd, 32'hCAFEF00D);
    chk("lat2_cycles", 2, cyc - c0, 3);

    // Latency 1: back-to-back reads, ready in cycles 2 and 4
    access(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1040, 32'hA5A5A5A5, 32'h4000, gf, gd);
    access(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1044, 32'h5A5A5A5A, 32'h4004, gf, gd);
    c0 = cyc;
    access(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1040, 32'h0, 32'h4008, gf, gd);
    chk("b2b_first", 1, gd, 32'hA5A5A5A5);
    access(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1044, 32'h0, 32'h400C, gf, gd);
    chk("b2b_second", 1, gd, 32'h5A5A5A5A);
    chk("b2b_cycles", 1, cyc - c0, 4);

    // Latency 3: reset in the second WAIT cycle abandons the write
    re_s[3] = 1'b0; we_s[3] = 1'b1; sz_s[3] = 2'b10; sg_s[3] = 1'b0;
    addr_s[3] = 32'd1048; wd_s[3] = 32'h12345678; pc_in_s[3] = 32'h5000;
    @(negedge clk);
    chk("rst_seq_freeze_idle", 3, 32'(freeze_s[3]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_freeze_wait1", 3, 32'(freeze_s[3]), 32'd1);
    @(posedge clk); #1;
    rst_s[3] = 1'b1;
    set_idle(3);
    @(posedge clk); #1;
    rst_s[3] = 1'b0;
    @(negedge clk);
    chk("rst_seq_freeze", 3, 32'(freeze_s[3]), 32'd0);
    chk("rst_seq_ready", 3, 32'(ready_s[3]), 32'd0);
    chk("rst_seq_pc", 3, pc_s[3], 32'h0);
    chk("rst_seq_memory_out", 3, mo_s[3], 32'h0);
    @(posedge clk); #1;
    mdl_reset(3);
    pc_exp[3] = 32'h5000;
    access(3, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1048, 32'h0, 32'h5004, gf, gd);
    chk("rst_seq_word_cleared", 3, gd, 32'h0);

    // Randomized accesses on every latency
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 40; t++) begin
        logic        re, we, sg;
        logic [1:0]  sz;
        logic [31:0] addr, wd, pcv;
        int          r;
        r = $urandom_range(0, 19);
        re = (r == 0) || (r < 10);
        we = (r == 0) || (r >= 10);
        sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        sg = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r < 7) begin
          addr = 32'd1024 + 32'($urandom_range(0, 255));
          if (sz != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
        end else if (r == 7) begin
          addr = 32'd1024 - 32'($urandom_range(1, 8));
        end else begin
          addr = 32'd1276 + 32'($urandom_range(0, 8));
        end
        wd  = $urandom;
        pcv = $urandom;
        access(k, re, we, sz, sg, addr, wd, pcv, gf, gd);
        if ($urandom_range(0, 4) == 0) begin
          pcv = $urandom;
          pc_in_s[k] = pcv;
          @(negedge clk);
          chk("idle_ready", k, 32'(ready_s[k]), 32'd0);
          chk("idle_freeze", k, 32'(freeze_s[k]), 32'd0);
          @(posedge clk); #1;
          pc_exp[k] = pcv;
          chk("idle_pc", k, pc_s[k], pcv);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ext.md
Name: mem_stage_ext

Overview:
Parametrised pipeline memory stage for the ARM core, sitting between EXE and WB. It owns the data memory and supports byte, halfword and word accesses with sign/zero extension. The memory has a configurable access latency, so the stage raises freeze to stall the upstream pipeline until the access completes. Misaligned, out-of-range and conflicting requests are reported on a fault flag.

Parameters:
WORD_LEN, 32, data width in bits; must be 32 (four byte lanes).
ADDRESS_LEN, 32, address and PC width.
DEPTH_WORDS, 64, number of words in the memory; power of two.
BASE_ADDR, 1024, byte address mapped to word 0.
MEM_LATENCY, 1, wait cycles per access (0..15).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
pc_in  in  ADDRESS_LEN  PC from EXE.
pc  out  ADDRESS_LEN  registered PC to WB.
MEM_R_EN  in  1  read request.
MEM_W_EN  in  1  write request.
MEM_SIZE  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (fault).
MEM_SIGNED  in  1  reads only: 1 sign-extends, 0 zero-extends.
ALU_Res  in  ADDRESS_LEN  byte address.
Val_RM  in  WORD_LEN  store data; low bits are used for sub-word stores.
memory_out  out  WORD_LEN  load result.
ready  out  1  access completes this cycle.
freeze  out  1  stall request to upstream stages.
fault  out  1  one-cycle pulse: access rejected.

Behaviour:
- Reset (synchronous, active-high) on the same edge:
  - state returns to IDLE and the wait counter clears;
  - pc, memory_out, ready, freeze and fault go to 0;
  - all memory words clear to 0;
  - any access in progress is abandoned and its write is never committed.
- Validity check, done combinationally in IDLE when MEM_R_EN or MEM_W_EN is high. Any failure makes the access faulted:
  - both enables high;
  - MEM_SIZE = 11;
  - half with ALU_Res[0]=1, or word with ALU_Res[1:0]!=0;
  - ALU_Res < BASE_ADDR, or ((ALU_Res-BASE_ADDR)>>2) >= DEPTH_WORDS.
- Faulted access:
  - fault=1 and ready=1 in that cycle, freeze=0;
  - memory is unchanged and memory_out keeps its previous value.
- FSM states: IDLE and WAIT. Counter cnt is 4 bits.
- IDLE, no enable: ready=0, freeze=0.
- IDLE, valid access, MEM_LATENCY=0:
  - completes this cycle: ready=1, freeze=0;
  - a write is committed at the closing edge;
  - read data appears on memory_out in the same cycle.
- IDLE, valid access, MEM_LATENCY>0:
  - freeze=1 and ready=0; go to WAIT with cnt=1.
- WAIT, cnt < MEM_LATENCY: freeze=1, cnt increments.
- WAIT, cnt = MEM_LATENCY:
  - ready=1, freeze=0;
  - a write commits at the closing edge and read data is driven;
  - return to IDLE.
- Total access time is MEM_LATENCY+1 cycles, with freeze high for MEM_LATENCY cycles.
- Upstream must hold all request inputs stable while freeze=1; the stage does not re-sample them.
- A new access may start in the cycle right after ready; back-to-back accesses insert no idle cycle.
- Lanes are little-endian, addressed by ALU_Res[1:0]:
  - byte store writes Val_RM[7:0] into lane ALU_Res[1:0];
  - half store writes Val_RM[15:0] into lanes {ALU_Res[1],0} and {ALU_Res[1],1};
  - other bytes of the word are preserved.
- Loads extract the addressed byte or half, then extend it per MEM_SIGNED to WORD_LEN.
- memory_out:
  - while ready=1 on a read, it is the combinational extended value;
  - that value is registered at the same edge and held until the next completed read;
  - writes do not change memory_out.
- pc loads pc_in on every edge where freeze=0 and holds while freeze=1.

Test Plan:
1. MEM_LATENCY=0: write word 0xDEADBEEF at 1024, then read 1024 -> ready=1 each cycle, freeze never set, memory_out=0xDEADBEEF.
2. MEM_LATENCY=2: read 1028 -> freeze=1,1 then ready=1 on cycle 3; pc holds its old value for 2 cycles, then updates.
3. Sub-word access: word 0x11223344 at 1032; byte store 0xAA to 1033 -> word=0x1122AA44. Signed byte load at 1033 -> 0xFFFFFFAA; unsigned half load at 1034 -> 0x00001122.
4. Faults, each -> fault=1 for one cycle, no freeze, memory unchanged:
   - half read at 1025 (misaligned);
   - word write at 1020 (below BASE_ADDR);
   - word write at 1024+4*64 (beyond DEPTH_WORDS);
   - both enables high.
5. Reset during a write, MEM_LATENCY=3: assert rst in the second WAIT cycle -> next cycle freeze=0, ready=0, the word reads back 0, and pc=0.
6. MEM_LATENCY=1: two back-to-back reads -> ready pulses in cycles 2 and 4; memory_out updates only at each ready.
